input_capture_fifo: RTL and testbench
=====================================

# input_capture_fifo

Downstream of the debounced push-button transmission stage. Captures the 31-bit operand `{y1,y2}` on each rising edge of that stage's `start` level, queues it in a small FIFO, and exposes it to the RV32 core as two memory-mapped words: DATA (pop-on-read) and STATUS (count, empty, full, sticky overflow). This lets software consume every operator entry without polling timing constraints.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CW`, 3: count width, equal to clog2(DEPTH)+1.

- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  capture request level from the transmission stage; held high for one or more cycles per button press.
- `din`  in  31  captured operand `{y1,y2}`; stable whenever `start` is high.
- `rd_en`  in  1  bus read strobe.
- `wr_en`  in  1  bus write strobe.
- `addr`  in  1  word select: 0 = DATA, 1 = STATUS.
- `wdata`  in  32  bus write data. Only STATUS bit 2 is used.
- `rdata`  out  32  registered read data.
- `avail`  out  1  high while the FIFO is non-empty. Driven from registered state.

## Operation
- Edge detect: `start_q` is the registered `start`. A push request is `start & ~start_q`. Holding `start` high produces exactly one push.
- Push: writes `din` to `mem[wp]`, then `wp` increments modulo DEPTH and `count` increments.
- Pop: occurs on `rd_en & (addr==0) & (count!=0)`. `rdata` takes `{1'b0, mem[rp]}`, then `rp` increments modulo DEPTH and `count` decrements.
- DATA read while empty: `rdata`=32'h0; no pointer or count change; not an error.
- STATUS read: `rdata` = {zero-fill, count[CW-1:0] at bits [4+CW-1:4], 0 at bit 3, ovf at bit 2, full at bit 1, empty at bit 0}. Reading STATUS has no side effects.
- Overflow: a push with count==DEPTH and no same-cycle pop drops `din` and sets sticky `ovf`. Pointers and count do not change.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged, including when the FIFO is full.
  - When the FIFO is empty, only the push takes effect: the read returns 0 and the new word is retained.
- Clearing overflow: `wr_en & (addr==1) & wdata[2]` clears `ovf`. If a new overflow occurs in the same cycle, the set wins.
- Writes to DATA are ignored.
- If `rd_en` and `wr_en` are asserted together, both are honoured independently.
- `rdata` holds its previous value on cycles with no `rd_en`.

## Timing
- Reset values: `rdata`=0, `avail`=0, `wp`=`rp`=0, `count`=0, `ovf`=0, `start_q`=0. Memory contents are undefined and unreset.
- Reset mid-operation discards all queued entries.
- If `start` is high on the first cycle after reset deasserts, that counts as a rising edge and pushes.
- Capture latency: `start` rises at cycle N → entry written and `avail`=1 at N+1.
- Read latency: `rd_en` sampled at edge N → `rdata` valid after edge N; count and pointers updated at edge N.
- Back-to-back DATA reads on consecutive cycles pop consecutive entries.
- `full`/`empty` are derived from `count`: full = (count==DEPTH), empty = (count==0). Pointers use log2(DEPTH) bits and wrap naturally.

## Structure
- Shared package `io_pkg` holds:
  - address constants `IO_ADDR_DATA`=0, `IO_ADDR_STATUS`=1;
  - STATUS bit indices `ST_EMPTY`=0, `ST_FULL`=1, `ST_OVF`=2, `ST_CNT_LSB`=4.
- One natural sub-module: `sync_fifo` (storage, pointers, count, full/empty, simultaneous push/pop).
- The top level holds:
  - the edge detector;
  - bus decode;
  - the overflow flag;
  - the `rdata` register.

## Test plan
- Reset, then `start` held high 5 cycles with `din`=31'h12345678 → exactly one push; STATUS read = 32'h10 (count=1, empty=0). DATA read → 32'h12345678. Following STATUS read → 32'h01.
- Five presses, `din`=1..5, DEPTH=4 → STATUS = 32'h46 (count 4, full, ovf). DATA reads return 1, 2, 3, 4, then 0.
- Write STATUS with `wdata`=32'h4 → ovf clears; STATUS = 32'h01.
- FIFO full (count 4) with a push and a DATA read in the same cycle → read returns the oldest entry; count stays 4; ovf stays 0. The new value is read last after the remaining three.
- FIFO empty with a push and a DATA read in the same cycle → `rdata`=0; next cycle `avail`=1, count=1; next DATA read returns the pushed value.
- Three entries queued, assert `rst` for 1 cycle mid-stream → `avail`=0, `rdata`=0, STATUS = 32'h01; wraparound is still correct after 10 further push/pop pairs.

Source files
------------

// File: rtl/io_pkg.sv
// Shared bus address map and STATUS word layout for the memory-mapped
// input capture block.
package io_pkg;

  localparam logic IO_ADDR_DATA   = 1'b0;
  localparam logic IO_ADDR_STATUS = 1'b1;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/input_capture_fifo_if.sv
// Core-side bus for the capture FIFO: read/write strobes, word select,
// write data and registered read data.
interface input_capture_fifo_if;

  logic        rd_en;
  logic        wr_en;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd_en, output wr_en, output addr, output wdata, input rdata);
  modport slave  (input rd_en, input wr_en, input addr, input wdata, output rdata);

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; a pop on an empty
// FIFO is ignored, and a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [30:0]   din,
  output logic [30:0]   dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [30:0]   mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_capture_fifo.sv
// Captures din on each rising edge of start into a FIFO and exposes it to
// the core as a pop-on-read DATA word and a STATUS word with sticky overflow.
module input_capture_fifo
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [30:0]            din,
  input_capture_fifo_if.slave    bus,
  output logic                   avail
);

  logic          start_q;
  logic          push_req;
  logic          rd_data;
  logic          rd_stat;
  logic          ovf_clr;
  logic          ovf_set;
  logic          ovf;
  logic [30:0]   dout;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [31:0]   status;
  logic          unused_wdata;

  assign push_req = start & ~start_q;
  assign rd_data  = bus.rd_en & (bus.addr == IO_ADDR_DATA);
  assign rd_stat  = bus.rd_en & (bus.addr == IO_ADDR_STATUS);
  assign ovf_clr  = bus.wr_en & (bus.addr == IO_ADDR_STATUS) & bus.wdata[ST_OVF];
  // A same-cycle DATA read frees a slot, so only an unaccompanied push overflows.
  assign ovf_set  = push_req & full & ~rd_data;
  assign avail    = ~empty;

  assign unused_wdata = ^{bus.wdata[31:3], bus.wdata[1:0]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd_data),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status                      = '0;
    status[ST_CNT_LSB +: CW]    = count;
    status[ST_OVF]              = ovf;
    status[ST_FULL]             = full;
    status[ST_EMPTY]            = empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      ovf       <= 1'b0;
      bus.rdata <= '0;
    end else begin
      start_q <= start;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (rd_data)      bus.rdata <= empty ? '0 : {1'b0, dout};
      else if (rd_stat) bus.rdata <= status;
    end
  end

endmodule

// File: tb/tb_input_capture_fifo.sv
// Directed bench for input_capture_fifo: capture, STATUS layout, overflow,
// simultaneous push/pop at full and empty, and reset mid-stream.
module tb_input_capture_fifo;

  logic        clk;
  logic        rst;
  logic        start;
  logic [30:0] din;
  logic        avail;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] rv;

  input_capture_fifo_if bus ();

  input_capture_fifo #(
    .DEPTH (4),
    .CW    (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .bus   (bus),
    .avail (avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [30:0] v);
    din   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic rd(input logic a, output logic [31:0] val);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    val = bus.rdata;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    din       = '0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_avail", {31'b0, avail}, 32'h0);
    rst = 1'b0;
    tick();

    // Level held 5 cycles gives one push
    din   = 31'h12345678;
    start = 1'b1;
    tick();
    check("capture_latency_avail", {31'b0, avail}, 32'h1);
    repeat (4) tick();
    start = 1'b0;
    tick();
    rd(1'b1, rv); check("single_push_status", rv, 32'h10);
    rd(1'b0, rv); check("single_push_data", rv, 32'h12345678);
    rd(1'b1, rv); check("after_pop_status", rv, 32'h01);
    tick();
    check("rdata_holds", bus.rdata, 32'h01);

    // Five presses into a depth-4 FIFO
    for (int unsigned i = 1; i <= 5; i++) press(31'(i));
    rd(1'b1, rv); check("overflow_status", rv, 32'h46);
    wr(1'b0, 32'hffff_ffff);
    rd(1'b1, rv); check("data_write_ignored", rv, 32'h46);
    for (int unsigned i = 1; i <= 4; i++) begin
      rd(1'b0, rv); check("ovf_drain", rv, 32'(i));
    end
    rd(1'b0, rv); check("empty_read_zero", rv, 32'h0);
    rd(1'b1, rv); check("ovf_sticky_status", rv, 32'h05);
    wr(1'b1, 32'h4);
    rd(1'b1, rv); check("ovf_cleared_status", rv, 32'h01);

    // Full FIFO: push and pop together
    for (int unsigned i = 10; i <= 13; i++) press(31'(i));
    din       = 31'd14;
    start     = 1'b1;
    bus.addr  = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    start     = 1'b0;
    bus.rd_en = 1'b0;
    check("full_pushpop_data", bus.rdata, 32'd10);
    rd(1'b1, rv); check("full_pushpop_status", rv, 32'h42);
    for (int unsigned i = 11; i <= 14; i++) begin
      rd(1'b0, rv); check("full_pushpop_drain", rv, 32'(i));
    end
    rd(1'b1, rv); check("full_pushpop_empty", rv, 32'h01);

    // Empty FIFO: push and pop together
    din       = 31'd21;
    start     = 1'b1;
    bus.addr  = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    start     = 1'b0;
    bus.rd_en = 1'b0;
    check("empty_pushpop_data", bus.rdata, 32'h0);
    check("empty_pushpop_avail", {31'b0, avail}, 32'h1);
    rd(1'b1, rv); check("empty_pushpop_status", rv, 32'h10);
    rd(1'b0, rv); check("empty_pushpop_retained", rv, 32'd21);

    // Reset mid-stream
    press(31'd31);
    press(31'd32);
    press(31'd33);
    rd(1'b1, rv); check("pre_reset_status", rv, 32'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_avail", {31'b0, avail}, 32'h0);
    check("midreset_rdata", bus.rdata, 32'h0);
    rd(1'b1, rv); check("midreset_status", rv, 32'h01);
    for (int unsigned i = 0; i < 10; i++) begin
      press(31'(100 + i));
      rd(1'b0, rv); check("wrap_pair", rv, 32'(100 + i));
    end
    rd(1'b1, rv); check("wrap_final_status", rv, 32'h01);

    // Start already high when reset releases counts as an edge
    rst   = 1'b1;
    din   = 31'h7abc;
    start = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_edge_avail", {31'b0, avail}, 32'h1);
    start = 1'b0;
    tick();
    rd(1'b0, rv); check("post_reset_edge_data", rv, 32'h7abc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
